// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: UART receiver that writes each good byte straight into a byte FIFO.
// Mid-bit sampling with a clocks-per-bit counter; 2-flop synchroniser on the serial line.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_feeder #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned W            = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          ODD_PARITY   = 1'b0
`endif
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_rx,
    input  logic         i_full,
    output logic         o_wr,
    output logic [W-1:0] o_data,
    output logic         o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic         o_parity_err,
`endif
    output logic         o_overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    logic           r_rx_meta;
    logic           r_rx_s;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [W-1:0]   r_shift;
    logic [W-1:0]   w_shift_nxt;
    logic           r_wr;
    logic           w_wr_nxt;
    logic [W-1:0]   r_data;
    logic [W-1:0]   w_data_nxt;
    logic           r_frame_err;
    logic           w_frame_err_nxt;
    logic           r_overrun;
    logic           w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
    logic           r_par;
    logic           w_par_nxt;
    logic           r_parity_err;
    logic           w_parity_err_nxt;
    logic           w_par_bad;

    // Received data plus parity bit must have the configured ones-count parity.
    assign w_par_bad = (^{r_shift, r_par}) ^ ODD_PARITY;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Next-state, counter, shift register and output-pulse logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_wr_nxt        = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt        = r_par;
        w_parity_err_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[W-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_rx_s;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_WAIT_HIGH;
                    end else begin
                        // Back to IDLE at mid-stop so a back-to-back start edge is caught.
                        w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (w_par_bad) begin
                            w_parity_err_nxt = 1'b1;
                        end else
`endif
                        if (i_full) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_wr_nxt   = 1'b1;
                            w_data_nxt = r_shift;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_wr        <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_wr        <= w_wr_nxt;
            r_data      <= w_data_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
            r_par        <= w_par_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    assign o_wr        = r_wr;
    assign o_data      = r_data;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
- UART receiver; sits directly upstream of the team's byte FIFO and writes each received byte into it.
- Synchronises the asynchronous serial line, detects and validates the start bit, and samples each bit at mid-bit using a clocks-per-bit counter (no oversampling).
- Presents a one-cycle write strobe plus data that connect directly to the FIFO write side. The FIFO full flag feeds back to drop bytes and report overruns.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Must be >= 4.
- W, 8, data bits per frame; sent LSB first.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idles high.
- i_full  input  1  FIFO full flag, sampled in the cycle the write would be issued.
- o_wr  output  1  one-cycle write strobe to the FIFO.
- o_data  output  W  received byte; valid while o_wr=1 and held until the next good frame.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: good byte dropped because i_full=1.

Behaviour:
- Synchroniser: 2 flops on i_rx, both reset to 1. The FSM sees only the second flop (rx_s).
- Counter: bit-period counter of width clog2(CLKS_PER_BIT); bit index counter of width clog2(W+1).
- Reset values: o_wr=0, o_data=0, o_frame_err=0, o_overrun=0, state=IDLE, counters=0.
- Reset mid-frame: abandons the frame with no strobe or error; the receiver returns to IDLE next cycle.
- IDLE:
  - rx_s=0 -> START, counter cleared.
- START:
  - Counts to (CLKS_PER_BIT-1)/2 (integer division), then samples rx_s.
  - rx_s=1 -> glitch: IDLE with no output.
  - rx_s=0 -> DATA, counter cleared, bit index 0.
- DATA:
  - Every CLKS_PER_BIT cycles, samples rx_s into a shift register. The first bit lands in bit 0 (LSB first).
  - After the W-th sample -> STOP (or PARITY if that feature is enabled).
- STOP:
  - After CLKS_PER_BIT cycles, samples rx_s.
  - rx_s=1 and i_full=0 -> next cycle o_wr=1 and o_data=shift register; state -> IDLE.
  - rx_s=1 and i_full=1 -> next cycle o_overrun=1, o_wr stays 0, o_data unchanged; state -> IDLE.
  - rx_s=0 -> next cycle o_frame_err=1, no write; state -> WAIT_HIGH.
- WAIT_HIGH:
  - Stays here while rx_s=0 (break condition); rx_s=1 -> IDLE.
- Return to IDLE at mid-stop-bit, so the next start edge of a back-to-back frame is caught.
- o_wr, o_frame_err and o_overrun are each high for exactly one cycle per frame and are mutually exclusive.
- Latency: o_wr rises one cycle after the stop sample point. The stop sample point is (CLKS_PER_BIT-1)/2 + 1 + (W+1)*CLKS_PER_BIT cycles after rx_s first goes low (W+2 with parity).
- i_full is only looked at in the stop-sample cycle. FIFO reads in the same cycle need no special handling.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one bit after CLKS_PER_BIT cycles.
  - Adds parameter ODD_PARITY (default 0 = even).
  - Adds output o_parity_err (1 bit, reset 0), pulsed one cycle at stop-evaluation time when parity mismatches.
  - A parity-failed byte is not written (o_wr=0). Frame error takes precedence; o_parity_err stays 0 in that case.
- Undefined:
  - No PARITY state, no o_parity_err port; the frame is exactly 1 start + W data + 1 stop bits.

Test Plan:
- CLKS_PER_BIT=8, i_full=0, send 0x55 with stop=1 -> exactly one o_wr pulse with o_data=0x55; no error pulses; o_data still 0x55 100 cycles later.
- Back-to-back 0xA5 then 0x3C with zero idle between frames -> two o_wr pulses 80 cycles apart, with o_data 0xA5 then 0x3C.
- i_rx low for 2 cycles, then high -> state back to IDLE; no o_wr, o_frame_err or o_overrun over the next 200 cycles.
- Send 0x81 with stop bit driven 0, then hold low 30 cycles -> one o_frame_err pulse, no o_wr. Then send 0x12 after the line returns high -> o_wr with 0x12.
- i_full=1 throughout, send 0x7E -> one o_overrun pulse, o_wr stays 0, o_data keeps its previous value. Then i_full=0, send 0x7E -> o_wr with 0x7E.
- Assert i_reset for 1 cycle in the middle of data bit 4 of a frame -> no pulse for that frame; a fresh 0xC3 sent afterwards is received correctly. With UART_RX_PARITY_EN and even parity, 0x07 with parity bit 0 -> o_parity_err pulse and no o_wr.
